instruction_fetch_unit: RTL and testbench

Sequencer that fetches one 16-bit instruction from the 8-bit-wide memory using the PC held in the address register file, and returns it as an instruction register value. It sits upstream of the address register file. It drives that file's RegSel/FunSel/OutDSel to read the PC and post-increment it once per byte fetched. It consumes the file's OutD as the memory address and hands the assembled instruction to the decode/control stage.

---
 rtl/instruction_fetch_unit_pkg.sv | 34 +++
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/instruction_fetch_unit_fetch_wait_timer.sv | 36 +++
 rtl/instruction_fetch_unit.sv | 89 ++++++++
 tb/tb_instruction_fetch_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and address-register-file control codes for the instruction fetch sequencer.
package instruction_fetch_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO_REQ,
        S_LO_INC,
        S_HI_REQ,
        S_HI_INC,
        S_DONE,
        S_FAULT
    } fetch_state_e;

    // Address register file function codes
    localparam logic [1:0] FUN_DEC   = 2'b00;
    localparam logic [1:0] FUN_INC   = 2'b01;
    localparam logic [1:0] FUN_LOAD  = 2'b10;
    localparam logic [1:0] FUN_CLEAR = 2'b11;

    // Address register file enable masks
    localparam logic [2:0] REG_NONE = 3'b000;
    localparam logic [2:0] REG_PC   = 3'b100;
    localparam logic [2:0] REG_SP   = 3'b010;
    localparam logic [2:0] REG_AR   = 3'b001;

    localparam logic [1:0] OUTD_PC = 2'b00;

    localparam int unsigned WAIT_W = 8;

    function automatic logic is_req_state(fetch_state_e s);
        return (s == S_LO_REQ) || (s == S_HI_REQ);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: start/PC from control and the register file, memory read port, IR result.
interface instruction_fetch_unit_if;

    logic        Start;
    logic [15:0] PCIn;
    logic [1:0]  OutDSel;
    logic [2:0]  RegSel;
    logic [1:0]  FunSel;
    logic [15:0] MemAddr;
    logic        MemRd;
    logic [7:0]  MemData;
    logic        MemAck;
    logic [15:0] IR;
    logic        IRValid;
    logic        Busy;
    logic        Fault;

    modport master (
        input  Start, PCIn, MemData, MemAck,
        output OutDSel, RegSel, FunSel, MemAddr, MemRd, IR, IRValid, Busy, Fault
    );

    modport slave (
        output Start, PCIn, MemData, MemAck,
        input  OutDSel, RegSel, FunSel, MemAddr, MemRd, IR, IRValid, Busy, Fault
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_wait_timer.sv
// Memory-acknowledge wait counter shared by both request states of the fetch sequencer.
module fetch_wait_timer
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [WAIT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the ack-less cycle whose count reaches MAX_WAIT, so the caller can leave on that edge.
    assign expired_o = en_i && !clear_i && (count_d == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches one little-endian 16-bit instruction as two byte reads, post-incrementing the PC per byte.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    instruction_fetch_unit_if.master  fetch
);

    fetch_state_e state_q, state_d;
    logic [7:0]   lo_buf_q, lo_buf_d;
    logic [15:0]  ir_q, ir_d;
    logic         tmr_clear, tmr_en, tmr_expired;
    logic         in_req, in_inc;

    assign in_req = is_req_state(state_q);
    assign in_inc = (state_q == S_LO_INC) || (state_q == S_HI_INC);

    // Counter is held clear outside the request states, so each request starts from zero.
    assign tmr_clear = !in_req;
    assign tmr_en    = in_req && !fetch.MemAck;

    fetch_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (tmr_clear),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        lo_buf_d = lo_buf_q;
        ir_d     = ir_q;
        unique case (state_q)
            S_IDLE: begin
                if (fetch.Start) state_d = S_LO_REQ;
            end
            S_LO_REQ: begin
                if (fetch.MemAck) begin
                    lo_buf_d = fetch.MemData;
                    state_d  = S_LO_INC;
                end else if (tmr_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_LO_INC: state_d = S_HI_REQ;
            S_HI_REQ: begin
                if (fetch.MemAck) begin
                    ir_d    = {fetch.MemData, lo_buf_q};
                    state_d = S_HI_INC;
                end else if (tmr_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_HI_INC: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_FAULT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            lo_buf_q <= '0;
            ir_q     <= '0;
        end else begin
            state_q  <= state_d;
            lo_buf_q <= lo_buf_d;
            ir_q     <= ir_d;
        end
    end

    assign fetch.OutDSel = OUTD_PC;
    assign fetch.RegSel  = in_inc ? REG_PC : REG_NONE;
    assign fetch.FunSel  = in_inc ? FUN_INC : FUN_DEC;
    assign fetch.MemAddr = fetch.PCIn;
    assign fetch.MemRd   = in_req;
    assign fetch.IR      = ir_q;
    assign fetch.IRValid = (state_q == S_DONE);
    assign fetch.Busy    = (state_q != S_IDLE);
    assign fetch.Fault   = (state_q == S_FAULT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed vector bench for instruction_fetch_unit with a PC register and byte-memory model.
module tb_instruction_fetch_unit;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          lo_d;       // ack on this REQ cycle index (0 = first), -1 = never
        int          hi_d;
        logic [7:0]  start_mask; // bit c drives Start in fetch cycle c
        logic [15:0] exp_ir;
        int          exp_valid;  // cycle of IRValid, -1 = none
        int          exp_fault;  // cycle of Fault, -1 = none
        int          exp_idle;   // first cycle back in IDLE
        int          exp_incs;
        logic [15:0] exp_pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(
        .MAX_WAIT(15)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .fetch (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] pc;
    logic [15:0] model_ir;
    int          cur_lo_d, cur_hi_d, ep, wcnt;
    logic        rd_prev;

    logic        s_busy, s_irvalid, s_fault, s_inc, s_ctl_bad, s_addr_bad;
    logic [15:0] s_ir;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: sample at negedge, answer the memory request, then update the PC model after the edge.
    task automatic tick();
        int dly;
        @(negedge clk);
        s_busy     = bus.Busy;
        s_irvalid  = bus.IRValid;
        s_fault    = bus.Fault;
        s_ir       = bus.IR;
        s_inc      = (bus.RegSel == 3'b100) && (bus.FunSel == 2'b01);
        s_ctl_bad  = !(s_inc || (bus.RegSel == 3'b000 && bus.FunSel == 2'b00)) || (bus.OutDSel != 2'b00);
        s_addr_bad = bus.MemRd && ((bus.MemAddr !== bus.PCIn) || (bus.PCIn != pc));
        if (bus.MemRd) begin
            if (!rd_prev) begin
                ep++;
                wcnt = 0;
            end
            dly = (ep == 1) ? cur_lo_d : cur_hi_d;
            bus.MemAck  = (dly >= 0) && (wcnt == dly);
            bus.MemData = mem[bus.PCIn];
            wcnt++;
        end else begin
            bus.MemAck  = 1'b0;
            bus.MemData = 8'h00;
        end
        rd_prev = bus.MemRd;
        @(posedge clk);
        #1;
        if (s_inc) pc = pc + 16'd1;
        bus.PCIn = pc;
    endtask

    task automatic run_fetch(input int idx, input vec_t v);
        int valid_c, fault_c, idle_c, incs, post_busy, limit, hold_lim;
        logic hold_ok, addr_ok, ctl_ok;
        valid_c = -1; fault_c = -1; idle_c = -1; incs = 0; post_busy = 0;
        hold_ok = 1'b1; addr_ok = 1'b1; ctl_ok = 1'b1;
        pc = v.pc;
        bus.PCIn = pc;
        mem[v.pc] = v.lo;
        mem[v.pc + 16'd1] = v.hi;
        cur_lo_d = v.lo_d;
        cur_hi_d = v.hi_d;
        ep = 0;
        rd_prev = 1'b0;
        limit = v.exp_idle + 3;
        hold_lim = (v.exp_valid >= 0) ? v.exp_valid - 1 : limit;
        for (int c = 0; c < limit; c++) begin
            bus.Start = (c < 8) ? v.start_mask[c] : 1'b0;
            tick();
            if (s_irvalid && valid_c < 0) valid_c = c;
            if (s_fault && fault_c < 0) fault_c = c;
            if (s_inc) incs++;
            if (s_ctl_bad) ctl_ok = 1'b0;
            if (s_addr_bad) addr_ok = 1'b0;
            if (c > 0 && !s_busy && idle_c < 0) idle_c = c;
            else if (idle_c >= 0 && s_busy) post_busy++;
            if (c < hold_lim && s_ir !== model_ir) hold_ok = 1'b0;
        end
        bus.Start = 1'b0;
        chk($sformatf("v%0d_ir", idx), 32'(s_ir), 32'(v.exp_ir));
        chk($sformatf("v%0d_valid_cycle", idx), valid_c, v.exp_valid);
        chk($sformatf("v%0d_fault_cycle", idx), fault_c, v.exp_fault);
        chk($sformatf("v%0d_idle_cycle", idx), idle_c, v.exp_idle);
        chk($sformatf("v%0d_inc_pulses", idx), incs, v.exp_incs);
        chk($sformatf("v%0d_pc_end", idx), 32'(pc), 32'(v.exp_pc));
        chk($sformatf("v%0d_ir_hold", idx), 32'(hold_ok), 32'd1);
        chk($sformatf("v%0d_addr_ok", idx), 32'(addr_ok), 32'd1);
        chk($sformatf("v%0d_ctl_ok", idx), 32'(ctl_ok), 32'd1);
        chk($sformatf("v%0d_busy_after_idle", idx), post_busy, 0);
        model_ir = v.exp_ir;
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({bus.Busy, bus.MemRd, bus.RegSel, bus.FunSel, bus.OutDSel,
                    bus.IRValid, bus.Fault, bus.IR});
    endfunction

    initial begin
        int incs, busy_cnt;
        vecs[0] = '{16'h0040, 8'h34, 8'h12,  0,  0, 8'h01,        16'h1234,  5, -1,  6, 2, 16'h0042};
        vecs[1] = '{16'h1000, 8'hCD, 8'hAB,  3,  3, 8'h01,        16'hABCD, 11, -1, 12, 2, 16'h1002};
        vecs[2] = '{16'h2000, 8'h55, 8'h66, -1, -1, 8'h01,        16'hABCD, -1, 16, 17, 0, 16'h2000};
        vecs[3] = '{16'hFFFF, 8'hEF, 8'hBE,  0,  1, 8'h01,        16'hBEEF,  6, -1,  7, 2, 16'h0001};
        vecs[4] = '{16'h3000, 8'h11, 8'h22,  0, -1, 8'h01,        16'hBEEF, -1, 18, 19, 1, 16'h3001};
        vecs[5] = '{16'h0100, 8'h78, 8'h56, 14, 14, 8'h01,        16'h5678, 33, -1, 34, 2, 16'h0102};
        vecs[6] = '{16'h0200, 8'h9A, 8'hBC, 15,  0, 8'h01,        16'h5678, -1, 16, 17, 0, 16'h0200};
        vecs[7] = '{16'h0500, 8'hC3, 8'hA5,  0,  0, 8'b0010_1101, 16'hA5C3,  5, -1,  6, 2, 16'h0502};

        bus.Start = 1'b0; bus.PCIn = '0; bus.MemAck = 1'b0; bus.MemData = '0;
        pc = '0; model_ir = '0; ep = 0; wcnt = 0; rd_prev = 1'b0;
        cur_lo_d = 0; cur_hi_d = 0;

        #12;
        chk("reset_outputs", out_vec(), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 8; i++) run_fetch(i, vecs[i]);

        // Asynchronous reset while parked in HI_REQ (high byte never acked).
        pc = 16'h0400; bus.PCIn = pc;
        mem[16'h0400] = 8'h11; mem[16'h0401] = 8'h22;
        cur_lo_d = 0; cur_hi_d = -1; ep = 0; rd_prev = 1'b0;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        chk("pre_reset_in_hireq", 32'({bus.Busy, bus.MemRd}), 32'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", out_vec(), 32'd0);
        chk("async_reset_pc", 32'(pc), 32'h0401);
        tick();
        tick();
        rst_n = 1'b1;
        model_ir = '0;
        incs = 0; busy_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (s_inc) incs++;
            if (s_busy) busy_cnt++;
        end
        chk("post_reset_incs", incs, 0);
        chk("post_reset_busy", busy_cnt, 0);
        chk("post_reset_pc", 32'(pc), 32'h0401);

        run_fetch(8, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
